// File: rtl/rv32i_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// mstatus bit positions and FSM state encodings.
package rv32i_trap_ctrl_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  localparam int unsigned MstatusMie    = 3;
  localparam int unsigned MstatusMpie   = 7;
  localparam int unsigned MstatusMppLo  = 11;
  localparam int unsigned MstatusMppHi  = 12;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StWMepc      = 3'd1,
    StWMcause    = 3'd2,
    StWMtval     = 3'd3,
    StWMstatus   = 3'd4,
    StRetMstatus = 3'd5,
    StRedirect   = 3'd6
  } trap_state_e;

  // Kind bit: which sequence is in flight.
  localparam logic KindTrap = 1'b0;
  localparam logic KindMret = 1'b1;

endpackage

// File: rtl/rv32i_mstatus_next.sv
// Computes the mstatus image written on trap entry (kind=0) or MRET (kind=1).
module rv32i_mstatus_next
  import rv32i_trap_ctrl_pkg::*;
(
  input  logic [31:0] mstatus,
  input  logic        kind,
  output logic [31:0] mstatus_next
);

  always_comb begin
    mstatus_next = mstatus;
    mstatus_next[MstatusMppHi:MstatusMppLo] = 2'b11;
    if (kind == KindMret) begin
      mstatus_next[MstatusMie]  = mstatus[MstatusMpie];
      mstatus_next[MstatusMpie] = 1'b1;
    end else begin
      mstatus_next[MstatusMpie] = mstatus[MstatusMie];
      mstatus_next[MstatusMie]  = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_trap_ctrl.sv
// Machine-mode trap/MRET sequencer. Owns the CSR write port, passes EX writes
// through when idle, and runs multi-cycle CSR update + PC redirect sequences.
module rv32i_trap_ctrl
  import rv32i_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_csr_we,
  input  logic [11:0] ex_csr_waddr,
  input  logic [31:0] ex_csr_wdata,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] mstatus_rdata,
  input  logic [31:0] mtvec_rdata,
  input  logic [31:0] mepc_rdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_e state_q;
  logic        kind_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [31:0] mstatus_next;

  rv32i_mstatus_next u_mstatus_next (
    .mstatus      (mstatus_rdata),
    .kind         (kind_q),
    .mstatus_next (mstatus_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kind_q  <= KindTrap;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trap_req) begin
            state_q <= StWMepc;
            kind_q  <= KindTrap;
            pc_q    <= {trap_pc[31:2], 2'b00};
            cause_q <= trap_cause;
            tval_q  <= trap_tval;
          end else if (mret_req) begin
            state_q <= StRetMstatus;
            kind_q  <= KindMret;
          end
        end
        StWMepc:      state_q <= StWMcause;
        StWMcause:    state_q <= StWMtval;
        StWMtval:     state_q <= StWMstatus;
        StWMstatus:   state_q <= StRedirect;
        StRetMstatus: state_q <= StRedirect;
        StRedirect:   state_q <= StIdle;
        default:      state_q <= StIdle;
      endcase
    end
  end

  // Sequence outputs come only from state and captured data; the request
  // inputs reach the outputs only in StIdle.
  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stall = trap_req | mret_req;
          // A winning trap or MRET drops the concurrent EX write.
          if (!(trap_req || mret_req)) begin
            csr_we    = ex_csr_we;
            csr_waddr = ex_csr_waddr;
            csr_wdata = ex_csr_wdata;
          end
        end
        StWMepc: begin
          csr_we    = 1'b1;
          csr_waddr = CsrMepc;
          csr_wdata = pc_q;
        end
        StWMcause: begin
          csr_we    = 1'b1;
          csr_waddr = CsrMcause;
          csr_wdata = cause_q;
        end
        StWMtval: begin
          csr_we    = 1'b1;
          csr_waddr = CsrMtval;
          csr_wdata = tval_q;
        end
        StWMstatus, StRetMstatus: begin
          csr_we    = 1'b1;
          csr_waddr = CsrMstatus;
          csr_wdata = mstatus_next;
        end
        StRedirect: begin
          redirect_valid = 1'b1;
          redirect_pc    = (kind_q == KindMret) ? (mepc_rdata & 32'hFFFF_FFFC)
                                                : (mtvec_rdata & MTVEC_MASK);
        end
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/rv32i_trap_ctrl.md
# rv32i_trap_ctrl

Machine-mode trap and MRET sequencer for the RV32I core. It owns the single CSR write port and shares it between the EX-stage system unit, which handles CSRRW/S/C and the immediate variants, and its own multi-cycle trap-entry and trap-return sequences. During a sequence it stalls the pipeline, writes mepc, mcause, mtval and mstatus one per cycle, and then issues a one-cycle PC redirect to mtvec or mepc.

## Interface
Parameters:
- MTVEC_MASK, 32'hFFFF_FFFC, mask applied to mtvec to form the trap target (direct mode only)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- ex_csr_we  in  1  CSR write request from the EX system unit
- ex_csr_waddr  in  12  EX CSR write address
- ex_csr_wdata  in  32  EX CSR write data
- trap_req  in  1  trap request from WB (exception or interrupt), one-cycle pulse
- trap_pc  in  32  PC of the trapping instruction
- trap_cause  in  32  mcause value
- trap_tval  in  32  mtval value
- mret_req  in  1  MRET retiring, one-cycle pulse
- mstatus_rdata  in  32  current mstatus
- mtvec_rdata  in  32  current mtvec
- mepc_rdata  in  32  current mepc
- csr_we  out  1  CSR file write enable
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  32  CSR file write data
- stall  out  1  freezes IF..EX while a sequence runs
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, RET_MSTATUS, REDIRECT.
- In IDLE the CSR port is a combinational pass-through of ex_csr_we, ex_csr_waddr and ex_csr_wdata.
- Request priority in IDLE is trap_req, then mret_req, then the EX write. The trapping instruction's EX write is dropped, and so is the EX write when mret_req wins.
- Trap accept (IDLE with trap_req): capture trap_pc, trap_cause and trap_tval into registers, then go to W_MEPC.
- Trap sequence: W_MEPC → W_MCAUSE → W_MTVAL → W_MSTATUS → REDIRECT.
  - W_MEPC writes 0x341 with {pc[31:2],2'b00}.
  - W_MCAUSE writes 0x342 with the captured cause.
  - W_MTVAL writes 0x343 with the captured tval.
  - W_MSTATUS writes 0x300.
- mstatus on trap entry: MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← 2'b11. All other bits come from mstatus_rdata as sampled in W_MSTATUS.
- MRET accept: go to RET_MSTATUS, then REDIRECT. RET_MSTATUS writes 0x300 with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11 (M-only core).
- REDIRECT: redirect_valid=1, then return to IDLE.
  - For a trap, redirect_pc = mtvec_rdata & MTVEC_MASK.
  - For MRET, redirect_pc = mepc_rdata & 32'hFFFF_FFFC.
  - A 1-bit kind register, set at accept, selects between the two.
- trap_req and mret_req are ignored outside IDLE. ex_csr_we is ignored outside IDLE because upstream is frozen by stall.

## Timing
- Reset: state=IDLE. csr_we=0, csr_waddr=0, csr_wdata=0, stall=0, redirect_valid=0, redirect_pc=0. Captured registers are cleared to 0.
- Reset mid-sequence returns to IDLE on the next edge. No further CSR writes and no redirect are issued.
- Trap latency: accept at cycle 0, writes in cycles 1–4, redirect in cycle 5. stall is high in cycles 0–5 inclusive.
- MRET latency: accept at cycle 0, write in cycle 1, redirect in cycle 2. stall is high in cycles 0–2.
- stall is combinational in IDLE (trap_req | mret_req) and registered-state-driven elsewhere.
- Sequence outputs are decoded from state and registered data only; they have no combinational path from the request inputs.
- Back-to-back: a trap_req in the cycle after REDIRECT is accepted normally.
- An EX write in the same cycle as trap_req is not performed.

## Structure
- Shared package (DEFINES) holds:
  - CSR addresses: MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343.
  - mstatus bit indices: MIE 3, MPIE 7, MPP 12:11.
  - FSM state encodings.
- One combinational sub-module is natural: rv32i_mstatus_next, which computes the trap-entry and MRET mstatus images from mstatus_rdata and the kind bit.

## Test plan
- EX pass-through: IDLE, ex_csr_we=1, waddr 0x340, wdata 0xDEADBEEF → same-cycle csr write of 0x340/0xDEADBEEF, stall=0.
- Trap entry with pc=0x0000_0104, cause=0x2, tval=0x0000_1073, mstatus=0x8, mtvec=0x0000_0201:
  - Writes 0x341=0x104, 0x342=0x2, 0x343=0x1073, 0x300=0x1880 in cycles 1–4.
  - Redirect to 0x200 in cycle 5; stall high in cycles 0–5.
- MRET with mstatus=0x1880, mepc=0x108 → cycle 1 writes 0x300=0x1888; cycle 2 redirects to 0x108.
- Collision: trap_req, mret_req and ex_csr_we all high in IDLE → trap sequence only, no write to the EX address, and a second mret_req pulse during W_MCAUSE is ignored.
- Reset asserted in W_MTVAL → next cycle all outputs are 0 and state is IDLE, with no mstatus write and no redirect.
